// File: rtl/unum4_norm.sv
// unum4_norm: two-stage pipelined normaliser for signed mantissa/exponent pairs.
// S1 captures the leading-sign count; S2 shifts the mantissa and adjusts the exponent, saturating on underflow.
module unum4_norm #(
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_MAX_W-1:0] man_in,
  input  logic [EXP_MAX_W-1:0] exp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_MAX_W-1:0] man_out,
  output logic [EXP_MAX_W-1:0] exp_out,
  output logic                 zero_out,
  output logic                 unf_out
);

  localparam int MW = MAN_MAX_W;
  localparam int EW = EXP_MAX_W;

  logic          s1_adv;
  logic          s2_adv;

  logic          s1_valid_reg;
  logic [MW-1:0] s1_man_reg;
  logic [EW-1:0] s1_exp_reg;
  logic [EW-1:0] s1_lz_reg;
  logic          s1_zero_reg;

  logic          s2_valid_reg;
  logic [MW-1:0] s2_man_reg;
  logic [EW-1:0] s2_exp_reg;
  logic          s2_zero_reg;
  logic          s2_unf_reg;

  logic [MW-1:1] sign_eq;
  logic          lz_run;
  logic [EW-1:0] lz_next;
  logic          zero_next;

  logic [EW:0]   exp_diff;
  logic [MW-1:0] man_next;
  logic [EW-1:0] exp_next;
  logic          unf_next;

  // Handshake: each stage may advance when it is empty or its successor frees up.
  assign s2_adv   = ~s2_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv & ~rst;

  genvar gi;
  generate
    for (gi = 1; gi < MW; gi++) begin : g_sign_eq
      assign sign_eq[gi] = (man_in[gi] == man_in[gi-1]);
    end
  endgenerate

  // Count the unbroken run of matching adjacent bits from the MSB downwards.
  always_comb begin
    lz_next = '0;
    lz_run  = 1'b1;
    for (int i = MW - 1; i >= 1; i--) begin
      lz_run  = lz_run & sign_eq[i];
      lz_next = lz_next + {{(EW-1){1'b0}}, lz_run};
    end
  end

  assign zero_next = (man_in == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_man_reg   <= '0;
      s1_exp_reg   <= '0;
      s1_lz_reg    <= '0;
      s1_zero_reg  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_man_reg  <= man_in;
        s1_exp_reg  <= exp_in;
        s1_lz_reg   <= lz_next;
        s1_zero_reg <= zero_next;
      end
    end
  end

  // The difference fits in EW+1 bits; underflow shows as the top two bits disagreeing.
  always_comb begin
    exp_diff = {s1_exp_reg[EW-1], s1_exp_reg} - {1'b0, s1_lz_reg};
    man_next = s1_man_reg << s1_lz_reg;
    unf_next = exp_diff[EW] & ~exp_diff[EW-1];
    exp_next = unf_next ? {1'b1, {(EW-1){1'b0}}} : exp_diff[EW-1:0];
    if (s1_zero_reg) begin
      man_next = '0;
      exp_next = '0;
      unf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_man_reg   <= '0;
      s2_exp_reg   <= '0;
      s2_zero_reg  <= 1'b0;
      s2_unf_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_man_reg  <= man_next;
        s2_exp_reg  <= exp_next;
        s2_zero_reg <= s1_zero_reg;
        s2_unf_reg  <= unf_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign man_out   = s2_man_reg;
  assign exp_out   = s2_exp_reg;
  assign zero_out  = s2_zero_reg;
  assign unf_out   = s2_unf_reg;

endmodule
